// File: rtl/ntt_scheduler.sv
// ntt_scheduler: sequencing controller for the 256-point Kyber NTT datapath.
// Walks 7 layers x 128 butterflies, emitting read addresses, the zeta index
// and two single-port write-backs per butterfly, and hands the RAM to an
// external loader while idle.
// Optional feature: define NTT_INVERSE_EN to enable Gentleman-Sande (inverse)
// ordering selected by `inv` at start.
module ntt_scheduler #(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       inv,
    input  logic       ext_req,
    output logic       ext_gnt,
    output logic       busy,
    output logic       done,
    output logic [7:0] ram_raddr_a,
    output logic [7:0] ram_raddr_b,
    output logic       ram_we,
    output logic [7:0] ram_waddr,
    output logic       wsel,
    output logic [6:0] zeta_idx,
    output logic [2:0] layer
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR_A, S_WR_B, S_DONE} state_t;

    state_t     state, state_nx;
    logic [1:0] wcnt;
    logic [7:0] j, grp, len;
    logic [6:0] k;
    logic [2:0] lyr;
    logic       fwd, fwd_in;
    logic       accept, active;
    logic [7:0] j_inc;
    logic [8:0] nxt_grp;
    logic       grp_end, layer_end, last;

`ifdef NTT_INVERSE_EN
    logic inv_q;
    assign fwd_in = ~inv;
    assign fwd    = ~inv_q;

    // Latch the transform direction when a start is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      inv_q <= 1'b0;
        else if (accept) inv_q <= inv;
    end
`else
    logic unused_inv;
    assign unused_inv = inv;
    assign fwd_in     = 1'b1;
    assign fwd        = 1'b1;
`endif

    // The external agent wins a simultaneous request, so start is masked by ext_req
    assign accept  = (state == S_IDLE) && start && !ext_req;
    assign ext_gnt = ext_req && (state == S_IDLE) && rst_n;
    assign active  = (state == S_RD) || (state == S_WAIT) ||
                     (state == S_WR_A) || (state == S_WR_B);

    // Group ends when j reaches start+len-1; layer ends when the next group
    // start carries past 255. The 9th bit of nxt_grp is that carry.
    assign j_inc     = j + 8'd1;
    assign grp_end   = (j_inc == grp + len);
    assign nxt_grp   = {1'b0, grp} + {len, 1'b0};
    assign layer_end = grp_end && nxt_grp[8];
    assign last      = layer_end && (fwd ? (len == 8'd2) : (len == 8'd128));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = S_RD;
            S_RD:   state_nx = S_WAIT;
            S_WAIT: if (wcnt == 2'(RD_LAT - 1)) state_nx = S_WR_A;
            S_WR_A: state_nx = S_WR_B;
            S_WR_B: state_nx = last ? S_DONE : S_RD;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Butterfly counters: initialised on accept, advanced on WR_B
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            j    <= '0;
            grp  <= '0;
            len  <= '0;
            k    <= '0;
            lyr  <= '0;
            wcnt <= '0;
        end else begin
            if (state == S_RD)        wcnt <= '0;
            else if (state == S_WAIT) wcnt <= wcnt + 2'd1;

            if (accept) begin
                j   <= '0;
                grp <= '0;
                len <= fwd_in ? 8'd128 : 8'd2;
                k   <= fwd_in ? 7'd1 : 7'd127;
                lyr <= '0;
            end else if (state == S_WR_B) begin
                if (layer_end) begin
                    j   <= '0;
                    grp <= '0;
                    len <= fwd ? (len >> 1) : (len << 1);
                    k   <= fwd ? (k + 7'd1) : (k - 7'd1);
                    lyr <= last ? 3'd0 : (lyr + 3'd1);
                end else if (grp_end) begin
                    j   <= nxt_grp[7:0];
                    grp <= nxt_grp[7:0];
                    k   <= fwd ? (k + 7'd1) : (k - 7'd1);
                end else begin
                    j   <= j_inc;
                end
            end
        end
    end

    // Output decode; addresses are held from RD through WR_B and forced to 0 otherwise
    always_comb begin
        busy        = active;
        done        = (state == S_DONE);
        ram_we      = 1'b0;
        ram_waddr   = '0;
        wsel        = 1'b0;
        ram_raddr_a = '0;
        ram_raddr_b = '0;
        zeta_idx    = '0;
        layer       = '0;
        if (active) begin
            ram_raddr_a = j;
            ram_raddr_b = j + len;
            zeta_idx    = k;
            layer       = lyr;
        end
        if (state == S_WR_A) begin
            ram_we    = 1'b1;
            ram_waddr = j;
        end else if (state == S_WR_B) begin
            ram_we    = 1'b1;
            ram_waddr = j + len;
            wsel      = 1'b1;
        end
    end
endmodule

// File: tb/tb_ntt_scheduler.sv
// Directed bench for ntt_scheduler (RD_LAT=1). Cycle numbers follow the
// convention that cycle 0 is the one in which start is sampled in IDLE.
module tb_ntt_scheduler;
    logic       clk = 1'b0;
    logic       rst_n, start, inv, ext_req;
    logic       ext_gnt, busy, done, ram_we, wsel;
    logic [7:0] ram_raddr_a, ram_raddr_b, ram_waddr;
    logic [6:0] zeta_idx;
    logic [2:0] layer;

    int errors = 0, checks = 0;
    int cyc, we_cnt, done_cnt, done_at;

    ntt_scheduler #(.RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .inv(inv), .ext_req(ext_req),
        .ext_gnt(ext_gnt), .busy(busy), .done(done),
        .ram_raddr_a(ram_raddr_a), .ram_raddr_b(ram_raddr_b),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .wsel(wsel),
        .zeta_idx(zeta_idx), .layer(layer)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sampling at the falling edge
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (ram_we) we_cnt++;
        if (done) begin
            done_cnt++;
            done_at = cyc;
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic begin_run(input logic inv_v);
        start = 1'b1; inv = inv_v;
        cyc = 0; we_cnt = 0; done_cnt = 0; done_at = 0;
        tick();
        start = 1'b0; inv = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".we"}, ram_we, 0);
        chk({tag, ".wsel"}, wsel, 0);
        chk({tag, ".gnt"}, ext_gnt, 0);
        chk({tag, ".ra"}, ram_raddr_a, 0);
        chk({tag, ".rb"}, ram_raddr_b, 0);
        chk({tag, ".wa"}, ram_waddr, 0);
        chk({tag, ".zeta"}, zeta_idx, 0);
        chk({tag, ".layer"}, layer, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; inv = 1'b0; ext_req = 1'b1;
        cyc = 0; we_cnt = 0; done_cnt = 0; done_at = 0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        ext_req = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Forward transform
        begin_run(1'b0);
        chk("bf0.busy", busy, 1);
        chk("bf0.ra", ram_raddr_a, 0);
        chk("bf0.rb", ram_raddr_b, 128);
        chk("bf0.zeta", zeta_idx, 1);
        chk("bf0.rd_we", ram_we, 0);
        tick();
        chk("bf0.wait_we", ram_we, 0);
        tick();
        chk("bf0.wra_we", ram_we, 1);
        chk("bf0.wra_addr", ram_waddr, 0);
        chk("bf0.wra_wsel", wsel, 0);
        chk("bf0.wra_rb_held", ram_raddr_b, 128);
        tick();
        chk("bf0.wrb_we", ram_we, 1);
        chk("bf0.wrb_addr", ram_waddr, 128);
        chk("bf0.wrb_wsel", wsel, 1);
        chk("bf0.wrb_zeta", zeta_idx, 1);
        tick();
        chk("bf1.ra", ram_raddr_a, 1);
        chk("bf1.rb", ram_raddr_b, 129);
        chk("bf1.zeta", zeta_idx, 1);

        // Start pulse while busy must be ignored; ext_req while busy not granted
        run_to(100);
        start = 1'b1;
        tick();
        start = 1'b0;
        ext_req = 1'b1;
        #1 chk("busy.gnt", ext_gnt, 0);
        tick();
        chk("busy.gnt2", ext_gnt, 0);
        chk("busy.still", busy, 1);
        ext_req = 1'b0;

        run_to(508);
        chk("bf127.layer", layer, 0);
        run_to(513);
        chk("bf128.layer", layer, 1);
        chk("bf128.ra", ram_raddr_a, 0);
        chk("bf128.rb", ram_raddr_b, 64);
        chk("bf128.zeta", zeta_idx, 2);
        run_to(769);
        chk("bf192.ra", ram_raddr_a, 128);
        chk("bf192.rb", ram_raddr_b, 192);
        chk("bf192.zeta", zeta_idx, 3);
        run_to(3581);
        chk("bf895.layer", layer, 6);
        chk("bf895.ra", ram_raddr_a, 253);
        chk("bf895.rb", ram_raddr_b, 255);
        chk("bf895.zeta", zeta_idx, 127);
        run_to(3584);
        chk("last.we", ram_we, 1);
        chk("last.wa", ram_waddr, 255);
        chk("last.busy", busy, 1);
        chk("last.done", done, 0);
        run_to(3585);
        chk("done.pulse", done, 1);
        chk("done.busy", busy, 0);
        chk("done.we", ram_we, 0);
        run_to(3586);
        chk("after.done", done, 0);

        // IDLE: simultaneous ext_req and start -> external agent wins
        ext_req = 1'b1; start = 1'b1;
        #1 chk("arb.gnt", ext_gnt, 1);
        run_to(3590);
        chk("arb.busy", busy, 0);
        chk("arb.gnt2", ext_gnt, 1);
        ext_req = 1'b0; start = 1'b0;
        run_to(3592);
        chk("fwd.done_cnt", done_cnt, 1);
        chk("fwd.done_at", done_at, 3585);
        chk("fwd.we_cnt", we_cnt, 1792);

        // Reset in the middle of a transform, then restart
        begin_run(1'b0);
        run_to(2000);
        chk("mid.we_before", ram_we, 1);
        rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        tick();
        rst_n = 1'b1;
        tick();
`ifdef NTT_INVERSE_EN
        begin_run(1'b0);
`else
        // inv has no effect in the forward-only build
        begin_run(1'b1);
`endif
        chk("restart.ra", ram_raddr_a, 0);
        chk("restart.rb", ram_raddr_b, 128);
        chk("restart.zeta", zeta_idx, 1);
        chk("restart.layer", layer, 0);
        run_to(3);
        chk("restart.wa", ram_waddr, 0);
        run_to(3590);
        chk("restart.done_at", done_at, 3585);
        chk("restart.we_cnt", we_cnt, 1792);

`ifdef NTT_INVERSE_EN
        begin_run(1'b1);
        chk("inv.ra", ram_raddr_a, 0);
        chk("inv.rb", ram_raddr_b, 2);
        chk("inv.zeta", zeta_idx, 127);
        run_to(3581);
        chk("inv.last_ra", ram_raddr_a, 127);
        chk("inv.last_rb", ram_raddr_b, 255);
        chk("inv.last_zeta", zeta_idx, 1);
        chk("inv.last_layer", layer, 6);
        run_to(3590);
        chk("inv.done_at", done_at, 3585);
        chk("inv.we_cnt", we_cnt, 1792);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
